// File: rtl/pe_fifo_scheduler.sv
// pe_fifo_scheduler: round-robin write arbiter for two producers plus a read-burst job FSM for one PE buffer FIFO.
module pe_fifo_scheduler #(
  parameter int WIDTH_DATA = 8,
  parameter int W_PARAM    = 4,
  parameter int R_PARAM    = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [WIDTH_DATA*W_PARAM-1:0] req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [WIDTH_DATA*W_PARAM-1:0] req1_data,
  output logic                          req1_ready,
  output logic [WIDTH_DATA*W_PARAM-1:0] fifo_inp,
  output logic                          fifo_write_en,
  input  logic                          fifo_able_write,
  output logic                          fifo_read_en,
  input  logic                          fifo_able_read,
  input  logic                          start,
  input  logic [CNT_W-1:0]              job_len,
  input  logic                          abort,
  output logic                          busy,
  output logic                          out_valid,
  output logic [CNT_W-1:0]              bursts_done,
  output logic                          done,
  output logic                          last_grant
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic ptr, grant1;
  logic [CNT_W-1:0] remaining;
  if (R_PARAM < 1 || W_PARAM < 1) begin : g_bad_beat
    $error("beat widths must be at least one word");
  end
  assign grant1        = req1_valid & (~req0_valid | ptr);
  assign fifo_write_en = (req0_valid | req1_valid) & fifo_able_write;
  assign fifo_inp      = grant1 ? req1_data : req0_data;
  assign req0_ready    = fifo_write_en & ~grant1;
  assign req1_ready    = fifo_write_en & grant1;
  assign fifo_read_en  = (state == RUN) & fifo_able_read & ~abort;
  assign busy          = state != IDLE;
  assign done          = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr        <= 1'b0;
      last_grant <= 1'b0;
    end else if (fifo_write_en) begin
      ptr        <= ~grant1;
      last_grant <= grant1;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((job_len == '0) ? DONE : RUN) : IDLE;
      RUN:     state_nx = abort ? IDLE : (fifo_read_en && remaining == CNT_W'(1)) ? DRAIN : RUN;
      DRAIN:   state_nx = abort ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      bursts_done <= '0;
      out_valid   <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= fifo_read_en;
      if (state == IDLE && start) begin
        remaining   <= job_len;
        bursts_done <= '0;
      end else if (fifo_read_en) begin
        remaining   <= remaining - CNT_W'(1);
        bursts_done <= bursts_done + CNT_W'(1);
      end
    end
endmodule
